div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_pkg.sv | 18 +
 rtl/div_cnt.sv | 30 +++
 rtl/div_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring-division controller: FSM states and
// the register-mode codes driven to the external shift registers.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_ITER = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SHL  = 2'd2;
  localparam logic [1:0] SHR  = 2'd3;

endpackage

// File: rtl/div_cnt.sv
// Iteration counter: loadable, decrements toward zero without wrapping, and
// flags the final iteration.
module div_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [CW-1:0] i_load_val,
  output logic          o_last
);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/div_ctrl.sv
// Control FSM for an N-bit restoring divider; the A/Q/B registers and the
// subtractor live outside and are steered through the sel_* mode codes.
module div_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       ge,
  input  logic       dz,
  output logic [1:0] sel_a,
  output logic [1:0] sel_q,
  output logic [1:0] sel_b,
  output logic       a_src,
  output logic       qbit,
  output logic       busy,
  output logic       done,
  output logic       dz_err
);

  import div_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   r_dz;
  logic   w_cnt_load;
  logic   w_cnt_dec;
  logic   w_last;

  div_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .clr_n      (clr_n),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (CW'(N)),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Remembers which path reached DONE so dz_err stays a pure state decode.
      if (r_state == ST_CHK) begin
        r_dz <= dz;
      end
    end
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    sel_a      = HOLD;
    sel_q      = HOLD;
    sel_b      = HOLD;
    a_src      = 1'b0;
    qbit       = 1'b0;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    dz_err     = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        sel_a      = LOAD;
        sel_q      = LOAD;
        sel_b      = LOAD;
        w_cnt_load = 1'b1;
        w_next     = ST_CHK;
      end
      ST_CHK: begin
        w_next = dz ? ST_DONE : ST_ITER;
      end
      ST_ITER: begin
        sel_q     = SHL;
        qbit      = ge;
        sel_a     = ge ? LOAD : SHL;
        a_src     = ge;
        w_cnt_dec = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        dz_err = r_dz;
        w_next = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
